// File: rtl/mips_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mips_controller : multicycle MIPS control FSM with opcode/funct decode
// Revision 1.0
// ----------------------------------------------------------------------------
module mips_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucont,
  output logic [1:0] pcsource,
  output logic       pcen
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_JEX     = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] aluop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (memready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_J:         state_d = S_JEX;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (memready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (memready) state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_RTYPEWB: state_d = S_FETCH;
      S_BEQEX:   state_d = S_FETCH;
      S_JEX:     state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    memread  = 1'b0;
    memwrite = 1'b0;
    iord     = 1'b0;
    irwrite  = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    pcsource = 2'b00;
    pcen     = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = memready;
        pcen    = memready;
      end
      S_DECODE:  alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsource = 2'b01;
        pcen     = zero;
      end
      S_JEX: begin
        pcsource = 2'b10;
        pcen     = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB:  regwrite = 1'b1;
      default: ;
    endcase
    // Reset holds state at FETCH asynchronously; only the write enables need masking.
    if (reset) begin
      pcen     = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
    end
  end

  always_comb begin
    alucont = 3'b010;
    case (aluop)
      2'b01: alucont = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: alucont = 3'b010;
          6'b100010: alucont = 3'b110;
          6'b100100: alucont = 3'b000;
          6'b100101: alucont = 3'b001;
          6'b101010: alucont = 3'b111;
          default:   alucont = 3'b010;
        endcase
      end
      default: alucont = 3'b010;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mips_controller : per-instruction cycle plans vs. mips_controller outputs
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_mips_controller;

  logic       clk, reset, zero, memready;
  logic [5:0] op, funct;
  logic       memread, memwrite, iord, irwrite, memtoreg, regdst, regwrite, alusrca, pcen;
  logic [1:0] alusrcb, pcsource;
  logic [2:0] alucont;
  logic [15:0] obs;

  int errors = 0;
  int checks = 0;

  localparam int P_FETCH  = 0;
  localparam int P_DECODE = 1;
  localparam int P_MEMADR = 2;
  localparam int P_MEMRD  = 3;
  localparam int P_MEMWB  = 4;
  localparam int P_MEMWR  = 5;
  localparam int P_RTEX   = 6;
  localparam int P_RTWB   = 7;
  localparam int P_BEQ    = 8;
  localparam int P_JEX    = 9;
  localparam int P_ADDIEX = 10;
  localparam int P_ADDIWB = 11;

  mips_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .alucont(alucont), .pcsource(pcsource), .pcen(pcen)
  );

  assign obs = {memread, memwrite, iord, irwrite, memtoreg, regdst, regwrite, alusrca,
                alusrcb, alucont, pcsource, pcen};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b (rd wr iord irw m2r rdst rw sa sb alc ps pcen)", tag, got, exp);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;  // add
      6'b100010: return 3'b110;  // sub
      6'b100100: return 3'b000;  // and
      6'b100101: return 3'b001;  // or
      6'b101010: return 3'b111;  // slt
      default:   return 3'b010;
    endcase
  endfunction

  // Expected outputs for one cycle of a given instruction phase.
  function automatic logic [15:0] expv(input int ph, input logic mr, input logic z,
                                       input logic [5:0] fn, input logic rs);
    logic mrd, mwr, iod, irw, m2r, rdst, rw, sa, pce;
    logic [1:0] sb, ps;
    logic [2:0] alc;
    mrd = 0; mwr = 0; iod = 0; irw = 0; m2r = 0; rdst = 0; rw = 0; sa = 0; pce = 0;
    sb = 2'b00; ps = 2'b00; alc = 3'b010;
    case (ph)
      P_FETCH:  begin mrd = 1; sb = 2'b01; irw = mr & ~rs; pce = mr & ~rs; end
      P_DECODE: sb = 2'b11;
      P_MEMADR: begin sa = 1; sb = 2'b10; end
      P_MEMRD:  begin mrd = 1; iod = 1; end
      P_MEMWB:  begin m2r = 1; rw = 1; end
      P_MEMWR:  begin mwr = 1; iod = 1; end
      P_RTEX:   begin sa = 1; alc = funct_alu(fn); end
      P_RTWB:   begin rdst = 1; rw = 1; end
      P_BEQ:    begin sa = 1; alc = 3'b110; ps = 2'b01; pce = z; end
      P_JEX:    begin ps = 2'b10; pce = 1; end
      P_ADDIEX: begin sa = 1; sb = 2'b10; end
      P_ADDIWB: rw = 1;
      default: ;
    endcase
    return {mrd, mwr, iod, irw, m2r, rdst, rw, sa, sb, alc, ps, pce};
  endfunction

  // Runs one instruction: fst fetch stalls, mst memory stalls, zmode 0/1 fixed zero or 2 random,
  // abort_at = step index at which reset is pulsed (-1 for none).
  task automatic run_instr(input logic [5:0] op_i, input logic [5:0] fn_i, input int fst,
                           input int mst, input int zmode, input int abort_at);
    int   ph_q[$];
    logic mr_q[$];
    int   ab;
    for (int k = 0; k < fst; k++) begin ph_q.push_back(P_FETCH); mr_q.push_back(1'b0); end
    ph_q.push_back(P_FETCH);  mr_q.push_back(1'b1);
    ph_q.push_back(P_DECODE); mr_q.push_back(rbit());
    case (op_i)
      6'b100011: begin
        ph_q.push_back(P_MEMADR); mr_q.push_back(rbit());
        for (int k = 0; k < mst; k++) begin ph_q.push_back(P_MEMRD); mr_q.push_back(1'b0); end
        ph_q.push_back(P_MEMRD); mr_q.push_back(1'b1);
        ph_q.push_back(P_MEMWB); mr_q.push_back(rbit());
      end
      6'b101011: begin
        ph_q.push_back(P_MEMADR); mr_q.push_back(rbit());
        for (int k = 0; k < mst; k++) begin ph_q.push_back(P_MEMWR); mr_q.push_back(1'b0); end
        ph_q.push_back(P_MEMWR); mr_q.push_back(1'b1);
      end
      6'b000000: begin
        ph_q.push_back(P_RTEX); mr_q.push_back(rbit());
        ph_q.push_back(P_RTWB); mr_q.push_back(rbit());
      end
      6'b000100: begin ph_q.push_back(P_BEQ); mr_q.push_back(rbit()); end
      6'b000010: begin ph_q.push_back(P_JEX); mr_q.push_back(rbit()); end
      6'b001000: begin
        ph_q.push_back(P_ADDIEX); mr_q.push_back(rbit());
        ph_q.push_back(P_ADDIWB); mr_q.push_back(rbit());
      end
      default: ;
    endcase
    ab = abort_at;
    if (ab >= ph_q.size()) ab = ph_q.size() - 1;
    foreach (ph_q[i]) begin
      @(posedge clk);
      #1;
      memready = mr_q[i];
      zero     = (zmode == 2) ? rbit() : (zmode == 1);
      if (ph_q[i] == P_FETCH) begin
        op    = 6'($urandom);
        funct = 6'($urandom);
      end else begin
        op    = op_i;
        funct = fn_i;
      end
      #1;
      chk($sformatf("op%b_step%0d_ph%0d", op_i, i, ph_q[i]), obs,
          expv(ph_q[i], memready, zero, funct, 1'b0));
      if (i == ab) begin
        memready = 1'b1;
        reset    = 1'b1;
        #1;
        chk("reset_async", obs, expv(P_FETCH, 1'b1, zero, funct, 1'b1));
        @(posedge clk);
        #1;
        chk("reset_held", obs, expv(P_FETCH, 1'b1, zero, funct, 1'b1));
        reset = 1'b0;
        #1;
        chk("reset_release_mr1", obs, expv(P_FETCH, 1'b1, zero, funct, 1'b0));
        memready = 1'b0;
        #1;
        chk("reset_release_mr0", obs, expv(P_FETCH, 1'b0, zero, funct, 1'b0));
        return;
      end
    end
  endtask

  function automatic logic [5:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 6'b100011;
      1:       return 6'b101011;
      2:       return 6'b000000;
      3:       return 6'b000100;
      4:       return 6'b000010;
      5:       return 6'b001000;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic logic [5:0] rand_funct();
    case ($urandom_range(0, 6))
      0:       return 6'b100000;
      1:       return 6'b100010;
      2:       return 6'b100100;
      3:       return 6'b100101;
      4:       return 6'b101010;
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    reset    = 1'b1;
    memready = 1'b1;
    zero     = 1'b0;
    op       = 6'd0;
    funct    = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs_mr1", obs, expv(P_FETCH, 1'b1, 1'b0, 6'd0, 1'b1));
    memready = 1'b0;
    #1;
    chk("reset_outputs_mr0", obs, expv(P_FETCH, 1'b0, 1'b0, 6'd0, 1'b1));
    reset = 1'b0;
    #1;
    chk("post_reset_fetch", obs, expv(P_FETCH, 1'b0, 1'b0, 6'd0, 1'b0));

    run_instr(6'b000000, 6'b101010, 0, 0, 2, -1);  // slt
    run_instr(6'b100011, 6'b000000, 0, 2, 2, -1);  // lw, 2 read stalls
    run_instr(6'b000100, 6'b000000, 0, 0, 1, -1);  // beq taken
    run_instr(6'b000100, 6'b000000, 0, 0, 0, -1);  // beq not taken
    run_instr(6'b101011, 6'b000000, 0, 1, 2, -1);  // sw, 1 write stall
    run_instr(6'b111111, 6'b000000, 2, 0, 2, -1);  // illegal op after fetch stalls
    run_instr(6'b000010, 6'b000000, 0, 0, 2, -1);  // j
    run_instr(6'b001000, 6'b000000, 1, 0, 2, -1);  // addi
    run_instr(6'b000000, 6'b100000, 0, 0, 2, 3);   // reset in RTYPEWB

    for (int n = 0; n < 80; n++) begin
      run_instr(rand_op(), rand_funct(), $urandom_range(0, 2), $urandom_range(0, 2), 2,
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 8)) : -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
